// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and asynchronous Cellular RAM sequencer
// Ports: clk, rst (sync, active high); req/we/addr/wdata in and ack out for ports 0 and 1;
//        rdata (last completed read), busy (ACCESS/RECOVER); MemAdr, MemDB and the
//        active-low RAM controls RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [22:0] addr0,
   input  logic [15:0] wdata0,
   output logic        ack0,
   input  logic        req1,
   input  logic        we1,
   input  logic [22:0] addr1,
   input  logic [15:0] wdata1,
   output logic        ack1,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [22:0] MemAdr,
   inout  wire  [15:0] MemDB,
   output logic        RamAdv,
   output logic        RamClk,
   output logic        RamCS,
   output logic        MemOE,
   output logic        MemWR,
   output logic        RamLB,
   output logic        RamUB
);
   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
   localparam logic [3:0] LAST = 4'(WAIT_CYCLES);
   state_t state;
   logic [3:0] cnt;
   logic last, port, we, drive, g1, g_we;
   logic [15:0] wdata;
   logic [6:0] ctl;
   // port 1 wins when alone, or on a tie when port 0 was served last
   assign g1 = req1 && (!req0 || !last);
   assign g_we = g1 ? we1 : we0;
   assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctl;
   assign MemDB = drive ? wdata : 16'bz;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         last <= 1'b1;
         port <= 1'b0;
         we <= 1'b0;
         drive <= 1'b0;
         wdata <= '0;
         ctl <= 7'b1111111;
         MemAdr <= '0;
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         rdata <= '0;
         busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req0 || req1) begin
               state <= ACCESS;
               port <= g1;
               last <= g1;
               we <= g_we;
               drive <= g_we;
               wdata <= g1 ? wdata1 : wdata0;
               MemAdr <= g1 ? addr1 : addr0;
               cnt <= '0;
               busy <= 1'b1;
               ctl <= g_we ? 7'b0001000 : 7'b0000100;
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST) begin
                  state <= RECOVER;
                  ctl <= 7'b1111111;
                  drive <= 1'b0;
                  if (!we) rdata <= MemDB;
                  ack0 <= !port;
                  ack1 <= port;
               end
            end
            RECOVER: begin
               state <= IDLE;
               ack0 <= 1'b0;
               ack1 <= 1'b0;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
